// File: rtl/spi_master_multi_if.sv
// Host-side handshake bundle for spi_master_multi: start/ready request channel
// and the one-cycle read-data strobe back to the configuration sequencer.
interface spi_master_multi_if #(
   parameter int DATA_W = 16,
   parameter int CS_W   = 2
);
   logic              start_in;
   logic [CS_W-1:0]   cs_sel_in;
   logic [DATA_W-1:0] tx_data_in;
   logic [DATA_W-1:0] rx_data_out;
   logic              rx_valid_out;
   logic              ready_out;
   logic              busy_out;

   modport master (
      input  start_in, cs_sel_in, tx_data_in,
      output rx_data_out, rx_valid_out, ready_out, busy_out
   );

   modport slave (
      output start_in, cs_sel_in, tx_data_in,
      input  rx_data_out, rx_valid_out, ready_out, busy_out
   );
endinterface

// File: rtl/spi_master_multi.sv
// Parametrised SPI master: programmable SCK divider, all CPOL/CPHA modes,
// one-hot active-low chip selects, MSB-first words of DATA_W bits.
module spi_master_multi #(
   parameter int DATA_W  = 16,
   parameter int NUM_CS  = 4,
   parameter int CLK_DIV = 2,
   parameter bit CPOL    = 1'b0,
   parameter bit CPHA    = 1'b0
) (
   input  logic               clk_in,
   input  logic               rst_n_in,
   spi_master_multi_if.master bus,
   output logic               spi_sck_out,
   output logic [NUM_CS-1:0]  spi_cs_n_out,
   output logic               spi_sdo_out,
   input  logic               spi_sdi_in
);
   localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
   localparam int BIT_W = $clog2(DATA_W + 1);
   localparam int DIV_W = $clog2(CLK_DIV + 1);
   localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

   state_t              r_state, w_next_state;
   logic [1:0]          r_rst_sync;
   logic                w_rst_n;
   logic [DIV_W-1:0]    r_div;
   logic [BIT_W-1:0]    r_bit, w_bit_next;
   logic                r_sck, r_sdo, r_rx_valid;
   logic [NUM_CS-1:0]   r_cs_n, w_cs_dec;
   logic [DATA_W-1:0]   r_tx, r_rx, r_rx_data;
   logic                w_div_zero, w_leading, w_toggle, w_sample, w_shift_edge, w_last;

   // NOTE: reset asserts asynchronously but is released on a clock edge so no
   // flop sees the deassertion inside its recovery window.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) r_rst_sync <= 2'b00;
      else           r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   assign w_div_zero   = (r_div == '0);
   assign w_leading    = (r_sck == CPOL);
   assign w_toggle     = (r_state == S_SHIFT) && w_div_zero;
   assign w_sample     = w_toggle && (w_leading != CPHA);
   assign w_shift_edge = w_toggle && (w_leading == CPHA);
   assign w_bit_next   = w_sample ? r_bit + BIT_W'(1) : r_bit;
   assign w_last       = w_toggle && !w_leading && (w_bit_next == BIT_LAST);

   always_ff @(posedge clk_in or negedge w_rst_n) begin
      if (!w_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next_state;
   end

   // NOTE: every variable written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_cs_dec     = '1;
      for (int i = 0; i < NUM_CS; i++)
         if (bus.cs_sel_in == CS_W'(i)) w_cs_dec[i] = 1'b0;
      case (r_state)
         S_IDLE:  if (bus.start_in) w_next_state = S_SETUP;
         S_SETUP: if (w_div_zero)   w_next_state = S_SHIFT;
         S_SHIFT: if (w_last)       w_next_state = S_HOLD;
         S_HOLD:  if (w_div_zero)   w_next_state = S_GAP;
         S_GAP:   if (w_div_zero)   w_next_state = S_IDLE;
         default:                   w_next_state = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // right-hand side reads the pre-edge value regardless of statement order.
   always_ff @(posedge clk_in or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_div      <= '0;
         r_bit      <= '0;
         r_sck      <= CPOL;
         r_sdo      <= 1'b0;
         r_cs_n     <= '1;
         r_tx       <= '0;
         r_rx       <= '0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         if (r_state == S_IDLE) begin
            if (bus.start_in) begin
               r_div  <= DIV_LOAD;
               r_bit  <= '0;
               r_sck  <= CPOL;
               r_cs_n <= w_cs_dec;
               if (CPHA) begin
                  r_tx  <= bus.tx_data_in;
                  r_sdo <= 1'b0;
               end else begin
                  r_tx  <= {bus.tx_data_in[DATA_W-2:0], 1'b0};
                  r_sdo <= bus.tx_data_in[DATA_W-1];
               end
            end
         end else begin
            // Every phase ends on a divider underflow, so this reload is also the phase-entry reload.
            r_div <= w_div_zero ? DIV_LOAD : r_div - DIV_W'(1);
            if (r_state == S_SETUP && w_div_zero) r_bit <= '0;
            if (w_toggle) begin
               r_sck <= ~r_sck;
               if (w_sample) begin
                  r_rx  <= {r_rx[DATA_W-2:0], spi_sdi_in};
                  r_bit <= w_bit_next;
               end
               if (w_shift_edge && !(!CPHA && w_last)) begin
                  r_sdo <= r_tx[DATA_W-1];
                  r_tx  <= {r_tx[DATA_W-2:0], 1'b0};
               end
            end
            if (r_state == S_HOLD && w_div_zero) begin
               r_cs_n     <= '1;
               r_sdo      <= 1'b0;
               r_rx_data  <= r_rx;
               r_rx_valid <= 1'b1;
            end
         end
      end
   end

   assign spi_sck_out      = r_sck;
   assign spi_cs_n_out     = r_cs_n;
   assign spi_sdo_out      = r_sdo;
   assign bus.rx_data_out  = r_rx_data;
   assign bus.rx_valid_out = r_rx_valid;
   assign bus.ready_out    = (r_state == S_IDLE);
   assign bus.busy_out     = (r_state != S_IDLE);
endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi: a mode-0 16-bit master looped back on
// itself, and a mode-3 8-bit master talking to a small slave model.
module tb_spi_master_multi;
   localparam int BUDGET = 400;
   localparam int LAT_A  = (2 * 16 + 2) * 2;  // rx_valid visible in cycle LAT_A+1 = 69
   localparam int LAT_B  = (2 * 8 + 2) * 1;   // visible in cycle 19

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   spi_master_multi_if #(.DATA_W(16), .CS_W(2)) if_a ();
   spi_master_multi_if #(.DATA_W(8),  .CS_W(2)) if_b ();

   logic       sck_a, sdo_a;
   logic [3:0] cs_n_a;
   logic       sck_b, sdo_b;
   logic [2:0] cs_n_b;
   logic       sdi_b = 1'b0;

   spi_master_multi #(.DATA_W(16), .NUM_CS(4), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0)) dut_a (
      .clk_in(clk), .rst_n_in(rst_n), .bus(if_a),
      .spi_sck_out(sck_a), .spi_cs_n_out(cs_n_a), .spi_sdo_out(sdo_a), .spi_sdi_in(sdo_a)
   );

   // NUM_CS=3 leaves cs_sel=3 representable, so the out-of-range select is exercised here.
   spi_master_multi #(.DATA_W(8), .NUM_CS(3), .CLK_DIV(1), .CPOL(1'b1), .CPHA(1'b1)) dut_b (
      .clk_in(clk), .rst_n_in(rst_n), .bus(if_b),
      .spi_sck_out(sck_b), .spi_cs_n_out(cs_n_b), .spi_sdo_out(sdo_b), .spi_sdi_in(sdi_b)
   );

   int          rise_a = 0, pulse_a = 0, rise_b = 0, pulse_b = 0;
   logic [15:0] sdo_cap_a = '0;
   logic [7:0]  mosi_b = '0;
   logic [7:0]  slave_word = 8'h3C;
   int          slv_idx = 0;
   wire         cs_b0 = cs_n_b[0];

   always @(posedge sck_a) begin
      rise_a++;
      sdo_cap_a = {sdo_cap_a[14:0], sdo_a};
   end
   always @(posedge sck_b) begin
      rise_b++;
      mosi_b = {mosi_b[6:0], sdo_b};
   end
   always @(posedge clk) begin
      if (if_a.rx_valid_out) pulse_a++;
      if (if_b.rx_valid_out) pulse_b++;
   end
   // Mode-3 slave: drives its next bit on each falling (leading) SCK edge.
   always @(negedge sck_b or posedge cs_b0) begin
      if (cs_b0) slv_idx = 0;
      else if (slv_idx < 8) begin
         sdi_b = slave_word[7 - slv_idx];
         slv_idx++;
      end
   end

   typedef struct {
      logic [15:0] tx;
      logic [1:0]  sel;
      logic [15:0] exp_rx;
      logic [3:0]  exp_cs;
      int          glitch;
   } vec_a_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_a(input int idx, input vec_a_t v);
      int          n, m, base_r, base_p;
      logic [3:0]  cs_and;
      string       t;
      t = $sformatf("a%0d", idx);
      base_r = rise_a;
      base_p = pulse_a;
      @(negedge clk);
      check({t, " ready_before"}, 64'(if_a.ready_out), 64'd1);
      if_a.start_in = 1'b1; if_a.tx_data_in = v.tx; if_a.cs_sel_in = v.sel;
      @(posedge clk);
      @(negedge clk);
      if_a.start_in = 1'b0; if_a.tx_data_in = ~v.tx; if_a.cs_sel_in = ~v.sel;
      check({t, " busy_after_accept"}, 64'(if_a.busy_out), 64'd1);
      n = 0;
      cs_and = '1;
      while (!if_a.rx_valid_out && n < BUDGET) begin
         cs_and &= cs_n_a;
         if (n == v.glitch) begin
            if_a.start_in = 1'b1; if_a.tx_data_in = 16'hFFFF;
         end else if (n == v.glitch + 1) if_a.start_in = 1'b0;
         @(posedge clk); n++;
         @(negedge clk);
      end
      check({t, " rx_valid_latency"}, 64'(n), 64'(LAT_A));
      check({t, " rx_data"}, 64'(if_a.rx_data_out), 64'(v.exp_rx));
      check({t, " cs_n_during"}, 64'(cs_and), 64'(v.exp_cs));
      check({t, " cs_n_released"}, 64'(cs_n_a), 64'hF);
      m = 0;
      while (!if_a.ready_out && m < BUDGET) begin
         @(posedge clk); m++;
         @(negedge clk);
      end
      check({t, " ready_after_valid"}, 64'(m), 64'd2);
      repeat (4) @(negedge clk);
      check({t, " sck_rises"}, 64'(rise_a - base_r), 64'd16);
      check({t, " sdo_stream"}, 64'(sdo_cap_a), 64'(v.tx));
      check({t, " rx_valid_pulses"}, 64'(pulse_a - base_p), 64'd1);
   endtask

   task automatic run_b(input string t, input logic [7:0] tx, input logic [1:0] sel,
                        input logic [2:0] exp_cs, input bit slave_on);
      int         n, m, base_r, base_p;
      logic [2:0] cs_and;
      base_r = rise_b;
      base_p = pulse_b;
      @(negedge clk);
      check({t, " sck_idle_high"}, 64'(sck_b), 64'd1);
      if_b.start_in = 1'b1; if_b.tx_data_in = tx; if_b.cs_sel_in = sel;
      @(posedge clk);
      @(negedge clk);
      if_b.start_in = 1'b0; if_b.tx_data_in = 8'h00;
      check({t, " sck_setup_cpol"}, 64'(sck_b), 64'd1);
      n = 0;
      cs_and = '1;
      while (!if_b.rx_valid_out && n < BUDGET) begin
         cs_and &= cs_n_b;
         @(posedge clk); n++;
         @(negedge clk);
      end
      check({t, " rx_valid_latency"}, 64'(n), 64'(LAT_B));
      check({t, " cs_n_during"}, 64'(cs_and), 64'(exp_cs));
      if (slave_on) begin
         check({t, " rx_data"}, 64'(if_b.rx_data_out), 64'h3C);
         check({t, " mosi_stream"}, 64'(mosi_b), 64'(tx));
      end
      m = 0;
      while (!if_b.ready_out && m < BUDGET) begin
         @(posedge clk); m++;
         @(negedge clk);
      end
      check({t, " ready_after_valid"}, 64'(m), 64'd1);
      repeat (3) @(negedge clk);
      check({t, " sck_rises"}, 64'(rise_b - base_r), 64'd8);
      check({t, " rx_valid_pulses"}, 64'(pulse_b - base_p), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_a_t     vecs [5];
      int         n, hi, rdy_at, low_at, base_p;
      logic [3:0] cs_low_val;

      vecs[0] = '{tx: 16'hA5C3, sel: 2'd0, exp_rx: 16'hA5C3, exp_cs: 4'b1110, glitch: 10};
      vecs[1] = '{tx: 16'h0001, sel: 2'd1, exp_rx: 16'h0001, exp_cs: 4'b1101, glitch: -5};
      vecs[2] = '{tx: 16'h8000, sel: 2'd2, exp_rx: 16'h8000, exp_cs: 4'b1011, glitch: -5};
      vecs[3] = '{tx: 16'hFFFF, sel: 2'd3, exp_rx: 16'hFFFF, exp_cs: 4'b0111, glitch: -5};
      vecs[4] = '{tx: 16'h0000, sel: 2'd2, exp_rx: 16'h0000, exp_cs: 4'b1011, glitch: -5};

      if_a.start_in = 1'b0; if_a.tx_data_in = '0; if_a.cs_sel_in = '0;
      if_b.start_in = 1'b0; if_b.tx_data_in = '0; if_b.cs_sel_in = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("reset cs_n_a", 64'(cs_n_a), 64'hF);
      check("reset sck_a", 64'(sck_a), 64'd0);
      check("reset sck_b", 64'(sck_b), 64'd1);
      check("reset sdo_a", 64'(sdo_a), 64'd0);
      check("reset rx_data_a", 64'(if_a.rx_data_out), 64'd0);
      check("reset rx_valid_a", 64'(if_a.rx_valid_out), 64'd0);
      check("reset ready_a", 64'(if_a.ready_out), 64'd1);
      check("reset busy_a", 64'(if_a.busy_out), 64'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      for (int i = 0; i < 5; i++) run_a(i, vecs[i]);

      run_b("b_mode3", 8'h96, 2'd0, 3'b110, 1'b1);
      run_b("b_no_cs", 8'h5A, 2'd3, 3'b111, 1'b0);

      // start_in held high across two words
      @(negedge clk);
      if_a.start_in = 1'b1; if_a.tx_data_in = 16'h1111; if_a.cs_sel_in = 2'd0;
      n = 0;
      while (!if_a.rx_valid_out && n < BUDGET) begin
         @(posedge clk); n++;
         @(negedge clk);
      end
      check("held word1 rx_data", 64'(if_a.rx_data_out), 64'h1111);
      if_a.tx_data_in = 16'h2222; if_a.cs_sel_in = 2'd3;
      hi = 0; rdy_at = -1; low_at = -1; cs_low_val = '1;
      for (int i = 0; i < 8; i++) begin
         if (cs_n_a == 4'hF) hi++;
         else if (low_at < 0) begin
            low_at = i; cs_low_val = cs_n_a; if_a.start_in = 1'b0;
         end
         if (if_a.ready_out && rdy_at < 0) rdy_at = i;
         @(posedge clk);
         @(negedge clk);
      end
      check("held cs_high_cycles", 64'(hi), 64'd3);
      check("held ready_rise", 64'(rdy_at), 64'd2);
      check("held accept_on_ready", 64'(low_at), 64'd3);
      check("held word2 cs_n", 64'(cs_low_val), 64'b0111);
      n = 0;
      while (!if_a.rx_valid_out && n < BUDGET) begin
         @(posedge clk); n++;
         @(negedge clk);
      end
      check("held word2 rx_data", 64'(if_a.rx_data_out), 64'h2222);
      repeat (4) @(negedge clk);

      // reset in the middle of SHIFT, just after bit 7 is sampled
      base_p = pulse_a;
      @(negedge clk);
      if_a.start_in = 1'b1; if_a.tx_data_in = 16'h3C3C; if_a.cs_sel_in = 2'd1;
      @(posedge clk);
      @(negedge clk);
      if_a.start_in = 1'b0;
      repeat (33) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst cs_n", 64'(cs_n_a), 64'hF);
      check("midrst sck", 64'(sck_a), 64'd0);
      check("midrst sdo", 64'(sdo_a), 64'd0);
      check("midrst rx_valid", 64'(if_a.rx_valid_out), 64'd0);
      check("midrst rx_data", 64'(if_a.rx_data_out), 64'd0);
      check("midrst ready", 64'(if_a.ready_out), 64'd1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("midrst no_pulse", 64'(pulse_a - base_p), 64'd0);
      run_a(5, '{tx: 16'h5A5A, sel: 2'd1, exp_rx: 16'h5A5A, exp_cs: 4'b1101, glitch: -5});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
